// File: rtl/imem_pkg.sv
// Shared definitions for the writable instruction memory boot path.
//   IMEM_DEPTH      : default number of instruction memory entries
//   IMEM_AW         : default address width, log2(IMEM_DEPTH)
//   NOP_INSTR       : RV32I canonical NOP (addi x0, x0, 0)
//   imem_ld_state_t : load controller states
package imem_pkg;

   localparam int unsigned IMEM_DEPTH = 64;
   localparam int unsigned IMEM_AW    = 6;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2
   } imem_ld_state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Boot-time loader for the writable instruction memory.
// Accepts a program stream over a valid/ready handshake, writes it from
// address 0 upward, fills the remaining entries with NOPs and then hands the
// memory read port to the core's fetch path.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ld_valid/ld_data/
//   ld_last/ld_ready      : loader stream handshake
//   start_load            : reload request (honoured in RUN and LOAD)
//   core_addr/core_instr/
//   core_stall            : core fetch path; core holds PC while stalled
//   mem_we/mem_waddr/
//   mem_wdata             : memory write port
//   mem_raddr/mem_rdata   : memory asynchronous read port
//   load_count            : words accepted in the most recent load
//   load_done             : one-cycle pulse on entry to RUN
module imem_load_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH,
   parameter int unsigned AW    = IMEM_AW,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_valid,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             ld_last,
   output logic             ld_ready,
   input  logic             start_load,
   input  logic [AW-1:0]    core_addr,
   output logic [WIDTH-1:0] core_instr,
   output logic             core_stall,
   output logic             mem_we,
   output logic [AW-1:0]    mem_waddr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [AW-1:0]    mem_raddr,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [AW:0]      load_count,
   output logic             load_done
);

   localparam logic [WIDTH-1:0] NOP_W     = WIDTH'(NOP_INSTR);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0]    ONE_PTR   = AW'(1);
   localparam logic [AW:0]      ONE_CNT   = (AW + 1)'(1);

   imem_ld_state_t state, state_nxt;
   logic [AW-1:0]  wptr, wptr_nxt;
   logic [AW:0]    count_nxt;
   logic [AW-1:0]  base_ptr;
   logic [AW:0]    base_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_LOAD;
         wptr       <= '0;
         load_count <= '0;
         load_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         wptr       <= wptr_nxt;
         load_count <= count_nxt;
         load_done  <= (state_nxt == ST_RUN) && (state != ST_RUN);
      end
   end

   always_comb begin
      state_nxt  = state;
      wptr_nxt   = wptr;
      count_nxt  = load_count;
      base_ptr   = wptr;
      base_count = load_count;
      ld_ready   = 1'b0;
      core_stall = 1'b1;
      core_instr = NOP_W;
      mem_we     = 1'b0;
      mem_waddr  = wptr;
      mem_wdata  = NOP_W;
      mem_raddr  = '0;

      unique case (state)
         ST_LOAD: begin
            ld_ready = 1'b1;
            // A restart takes effect in the same cycle, so a word accepted
            // alongside start_load lands at address 0 as word 1.
            if (start_load) begin
               base_ptr   = '0;
               base_count = '0;
            end
            wptr_nxt  = base_ptr;
            count_nxt = base_count;
            if (ld_valid) begin
               mem_we    = 1'b1;
               mem_waddr = base_ptr;
               mem_wdata = ld_data;
               count_nxt = base_count + ONE_CNT;
               // Top entry is an implicit last word; wptr never wraps by
               // increment, it is only cleared on LOAD entry.
               if (base_ptr == LAST_ADDR) begin
                  state_nxt = ST_RUN;
               end else begin
                  wptr_nxt = base_ptr + ONE_PTR;
                  if (ld_last) begin
                     state_nxt = ST_CLEAR;
                  end
               end
            end
         end

         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = wptr;
            mem_wdata = NOP_W;
            if (wptr == LAST_ADDR) begin
               state_nxt = ST_RUN;
            end else begin
               wptr_nxt = wptr + ONE_PTR;
            end
         end

         ST_RUN: begin
            core_stall = 1'b0;
            mem_raddr  = core_addr;
            core_instr = mem_rdata;
            if (start_load) begin
               state_nxt = ST_LOAD;
               wptr_nxt  = '0;
               count_nxt = '0;
            end
         end

         default: begin
            state_nxt = ST_LOAD;
            wptr_nxt  = '0;
            count_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl with a behavioural memory image model.
module tb_imem_load_ctrl;
   import imem_pkg::*;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned WIDTH = 32;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ld_valid = 1'b0;
   logic [WIDTH-1:0] ld_data = '0;
   logic             ld_last = 1'b0;
   logic             ld_ready;
   logic             start_load = 1'b0;
   logic [AW-1:0]    core_addr = '0;
   logic [WIDTH-1:0] core_instr;
   logic             core_stall;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic [AW-1:0]    mem_raddr;
   logic [WIDTH-1:0] mem_rdata;
   logic [AW:0]      load_count;
   logic             load_done;

   imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .start_load(start_load),
      .core_addr(core_addr), .core_instr(core_instr), .core_stall(core_stall),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .load_count(load_count), .load_done(load_done)
   );

   always #5 clk = ~clk;

   // environment memory standing in for imem_rw
   logic [31:0] mem [DEPTH];
   always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
   assign mem_rdata = mem[mem_raddr];

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
   wr_t         wr_q[$];
   int unsigned done_q[$];

   // reference image of what the core should fetch after a completed load
   logic [31:0] img  [DEPTH];
   logic [31:0] prog [$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // monitor: pops expectations whenever the DUT presents a write or load_done
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_write", 64'(mem_waddr), 64'hFFFF);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               chk("write_addr", 64'(mem_waddr), 64'(e.addr));
               chk("write_data", 64'(mem_wdata), 64'(e.data));
            end
         end
         if (load_done) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", 64'(load_count), 64'hFFFF);
            end else begin
               chk("done_count", 64'(load_count), 64'(done_q.pop_front()));
               chk("done_unstalled", 64'(core_stall), 64'd0);
            end
         end
         if (core_stall) chk("stall_nop", 64'(core_instr), 64'(NOP));
      end
   end

   task automatic send_word(input logic [31:0] d, input bit last, input bit restart,
                            input int unsigned addr, input int unsigned gap_max);
      repeat ($urandom_range(gap_max, 0)) begin
         @(posedge clk); #1;
      end
      ld_valid = 1'b1; ld_data = d; ld_last = last; start_load = restart;
      wr_q.push_back('{addr: AW'(addr), data: d});
      @(negedge clk);
      chk("ld_ready_load", 64'(ld_ready), 64'd1);
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0; start_load = 1'b0; ld_data = $urandom;
   endtask

   // streams prog[0..n-1]; returns in the cycle after the last word is accepted
   task automatic stream(input int unsigned n, input bit use_last, input bit restart_first);
      for (int unsigned i = 0; i < n; i++)
         send_word(prog[i], use_last && (i == n - 1), restart_first && (i == 0), i, 2);
      for (int unsigned i = n; i < DEPTH; i++) wr_q.push_back('{addr: AW'(i), data: NOP});
      done_q.push_back(n);
      for (int unsigned i = 0; i < DEPTH; i++) img[i] = (i < n) ? prog[i] : NOP;
   endtask

   task automatic wait_run(input int unsigned n, input bit pulse_clear);
      int unsigned c = 1;
      bit seen = 0;
      while (c < 200 && !seen) begin
         start_load = (c == 1 && pulse_clear && n < DEPTH);
         @(negedge clk);
         if (load_done) seen = 1;
         else begin
            @(posedge clk); #1; c++;
         end
      end
      start_load = 1'b0;
      chk("run_reached", 64'(seen), 64'd1);
      chk("run_latency", 64'(c), 64'(DEPTH + 1 - n));
      @(posedge clk); #1;
   endtask

   task automatic read_all();
      for (int unsigned a = 0; a < DEPTH; a++) begin
         core_addr = AW'(a); #1;
         chk("fetch", 64'(core_instr), 64'(img[a]));
      end
   endtask

   task automatic reload_from_run();
      start_load = 1'b1;
      @(posedge clk); #1;
      start_load = 1'b0;
      chk("reload_stall", 64'(core_stall), 64'd1);
      chk("reload_count", 64'(load_count), 64'd0);
      chk("reload_ready", 64'(ld_ready), 64'd1);
   endtask

   task automatic reset_checks();
      chk("rst_ld_ready", 64'(ld_ready), 64'd1);
      chk("rst_stall", 64'(core_stall), 64'd1);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_count", 64'(load_count), 64'd0);
      chk("rst_done", 64'(load_done), 64'd0);
      chk("rst_instr", 64'(core_instr), 64'(NOP));
   endtask

   task automatic rand_prog(input int unsigned n);
      prog.delete();
      for (int unsigned i = 0; i < n; i++) prog.push_back($urandom);
   endtask

   initial begin
      int unsigned n;
      int unsigned guard;
      #3;
      reset_checks();
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // directed 4-word program
      prog.delete();
      prog.push_back(32'h0050_0093); prog.push_back(32'h0010_8133);
      prog.push_back(32'h0020_81B3); prog.push_back(32'h4020_8233);
      stream(4, 1, 0);
      wait_run(4, 0);
      core_addr = 6'd2; #1;
      chk("fetch_addr2", 64'(core_instr), 64'h0020_81B3);
      read_all();
      reload_from_run();

      // full 64-word program, no ld_last
      rand_prog(DEPTH);
      stream(DEPTH, 0, 0);
      wait_run(DEPTH, 0);
      chk("full_ready", 64'(ld_ready), 64'd0);
      chk("full_count", 64'(load_count), 64'(DEPTH));
      read_all();
      reload_from_run();

      // junk words then restart in LOAD; start_load pulsed during CLEAR
      for (int unsigned i = 0; i < 3; i++) send_word($urandom, 0, 0, i, 1);
      rand_prog(10);
      stream(10, 1, 1);
      wait_run(10, 1);
      read_all();

      // randomized loads
      for (int unsigned it = 0; it < 5; it++) begin
         reload_from_run();
         n = $urandom_range(DEPTH, 1);
         rand_prog(n);
         stream(n, (n < DEPTH) ? 1'b1 : 1'($urandom_range(1, 0)), 0);
         wait_run(n, 1'($urandom_range(1, 0)));
         read_all();
      end

      // reset in the middle of CLEAR
      reload_from_run();
      rand_prog(5);
      stream(5, 1, 0);
      guard = 0;
      do begin
         @(negedge clk); guard++;
      end while (!(mem_we && mem_waddr == 6'd20) && guard < 200);
      chk("clear_at_20", 64'(guard < 200), 64'd1);
      #2 rst_n = 1'b0;
      wr_q.delete(); done_q.delete();
      #1;
      reset_checks();
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      rand_prog(1);
      stream(1, 1, 0);
      wait_run(1, 0);
      read_all();

      repeat (2) @(posedge clk);
      chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
      chk("done_q_empty", 64'(done_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-time controller for the writable instruction memory of the single-cycle core. Accepts a program stream from a host loader over a valid/ready handshake and writes it word-by-word into the 64-entry memory. It then fills the unused tail with NOPs and releases the core to fetch. Sits between the loader, the memory's write/read ports and the core's fetch path; the core stalls whenever the controller is not in RUN.

## Interface
- `DEPTH`, 64, instruction memory entries (power of two)
- `AW`, 6, address width, log2(DEPTH)
- `WIDTH`, 32, instruction width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ld_valid`  in  1  loader word valid
- `ld_data`  in  WIDTH  loader instruction word
- `ld_last`  in  1  qualifies `ld_data` as final program word
- `ld_ready`  out  1  controller accepts a word this cycle
- `start_load`  in  1  request reload (honoured in RUN and LOAD)
- `core_addr`  in  AW  core fetch word address
- `core_instr`  out  WIDTH  instruction to core
- `core_stall`  out  1  core must hold PC
- `mem_we`  out  1  memory write enable
- `mem_waddr`  out  AW  memory write address
- `mem_wdata`  out  WIDTH  memory write data
- `mem_raddr`  out  AW  memory async read address
- `mem_rdata`  in  WIDTH  memory read data
- `load_count`  out  AW+1  words accepted from loader in last load (0..DEPTH)
- `load_done`  out  1  one-cycle pulse on entry to RUN

## Operation
- States: LOAD, CLEAR, RUN. Reset enters LOAD, `wptr`=0, `load_count`=0.
- LOAD: `ld_ready`=1, `core_stall`=1, `core_instr`=NOP (32'h0000_0013). Accept on `ld_valid&&ld_ready`: `mem_we`=1, `mem_waddr`=`wptr`, `mem_wdata`=`ld_data`; `wptr`++, `load_count`++.
- End of load: accepted word with `ld_last`=1, or accepted word at `wptr`=DEPTH-1 (implicit last; `ld_last` ignored). Next state CLEAR if `wptr`+1<DEPTH, else RUN.
- CLEAR: `ld_ready`=0, `core_stall`=1; `mem_we`=1, `mem_wdata`=NOP, `mem_waddr`=`wptr`, `wptr`++ each cycle; after writing DEPTH-1 go to RUN.
- RUN: `ld_ready`=0, `core_stall`=0, `mem_we`=0, `mem_raddr`=`core_addr`, `core_instr`=`mem_rdata`. `start_load`=1 -> LOAD, `wptr`=0, `load_count`=0.
- `start_load` in LOAD: restart (`wptr`=0, `load_count`=0); a word accepted in the same cycle is written at address 0 and counts as word 1. Ignored in CLEAR.
- Outside RUN, `mem_raddr`=0.
- `load_count` holds its value through CLEAR and RUN until the next LOAD entry.
- Memory contents are not touched by reset.

## Timing
- Reset values: `ld_ready`=1, `core_stall`=1, `mem_we`=0 (LOAD with `ld_valid`=0), `load_count`=0, `load_done`=0, `core_instr`=NOP.
- `ld_ready`, `core_stall`, `mem_*` and `core_instr` are combinational from state, `wptr` and inputs. `state`, `wptr`, `load_count` and `load_done` are registered.
- Word accepted in cycle N is written at the rising edge ending cycle N.
- Last word at index k<DEPTH-1 accepted in cycle N: CLEAR in cycles N+1..N+DEPTH-1-k, RUN from N+DEPTH-k; `load_done` high in that first RUN cycle only.
- Last word at index DEPTH-1: RUN in cycle N+1.
- `wptr` wraps DEPTH-1 -> 0 only via the LOAD entry reset, never by increment.
- `rst_n` low in any state: immediately LOAD, `wptr`=0, all outputs at reset values; a partial CLEAR is abandoned.

## Structure
- Shared package `imem_pkg`: `NOP_INSTR` constant, state enum `imem_ld_state_t`, `IMEM_DEPTH`/`IMEM_AW` defaults.
- No sub-module; FSM, `wptr` and counter are inline. The writable memory `imem_rw` is instantiated beside this block at top level.

## Test plan
- Reset, stream 4 words (0x00500093, 0x00108133, 0x002081B3, `ld_last` on 4th) -> addresses 0..3 written, CLEAR writes NOP to 4..63 (60 cycles), `load_done` pulse, `load_count`=4, `core_stall`=0.
- 64 words, `ld_last` never asserted -> RUN the cycle after word 63, no CLEAR, `load_count`=64, `ld_ready`=0.
- `ld_valid` toggled with gaps -> only handshake cycles write, addresses contiguous, `core_instr`=NOP until RUN.
- In RUN, `core_addr`=2 -> `core_instr`=0x002081B3. `start_load` -> LOAD next cycle, `core_stall`=1, `load_count`=0.
- Deassert `rst_n` mid-CLEAR at `wptr`=20 -> LOAD immediately, `ld_ready`=1. Reload 1 word -> CLEAR covers 1..63.
- `start_load` in CLEAR -> ignored, RUN reached on schedule.
